control_unit: RTL

Sequencing controller for the K&S processor `data_path`. It runs a fixed fetch/decode/execute state machine. From the decoded instruction and the registered ALU flags it drives every datapath control strobe (PC, IR, address mux, register-file write, flags write, ALU operation). It also drives the RAM write strobe and a halt indication. It sits beside `data_path` in the processor top, and both share the same clock and reset.

---
 rtl/control_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// K&S processor sequencer: fetch/decode/execute FSM driving the data_path
// control strobes, RAM write strobe, halt flag and retired-instruction count.
package k_and_s_pkg;
   typedef enum logic [3:0] {
      I_NOP    = 4'd0,
      I_LOAD   = 4'd1,
      I_STORE  = 4'd2,
      I_MOVE   = 4'd3,
      I_ADD    = 4'd4,
      I_SUB    = 4'd5,
      I_AND    = 4'd6,
      I_OR     = 4'd7,
      I_BRANCH = 4'd8,
      I_BZERO  = 4'd9,
      I_BNZERO = 4'd10,
      I_BNEG   = 4'd11,
      I_BNNEG  = 4'd12,
      I_BOV    = 4'd13,
      I_HALT   = 4'd14
   } decoded_instruction_type;
endpackage

module control_unit
   import k_and_s_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halt,
   output logic [COUNT_W-1:0]      instr_count
);

   typedef enum logic [2:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   state_t state;
   logic   armed;
   logic   short_instr;
   logic   take;
   logic   retire;
   logic   unused_flags;

   assign unused_flags = unsigned_overflow;

   always_comb begin
      short_instr = 1'b1;
      case (decoded_instruction)
         I_LOAD, I_STORE, I_MOVE,
         I_ADD, I_SUB, I_AND, I_OR,
         I_BRANCH, I_BZERO, I_BNZERO,
         I_BNEG, I_BNNEG, I_BOV,
         I_HALT: short_instr = 1'b0;
         default: short_instr = 1'b1;
      endcase
   end

   always_comb begin
      take = 1'b0;
      case (decoded_instruction)
         I_BRANCH: take = 1'b1;
         I_BZERO:  take = zero_op;
         I_BNZERO: take = !zero_op;
         I_BNEG:   take = neg_op;
         I_BNNEG:  take = !neg_op;
         I_BOV:    take = signed_overflow;
         default:  take = 1'b0;
      endcase
   end

   assign retire = (state == S_EXEC)
                || (state == S_DECODE && short_instr);

   // armed holds S_INIT for one full cycle after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_INIT;
         armed       <= 1'b0;
         instr_count <= '0;
      end else begin
         armed <= 1'b1;
         if (retire)
            instr_count <= instr_count + ONE;
         unique case (state)
            S_INIT:   if (armed) state <= S_FETCH;
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               if (decoded_instruction == I_HALT)
                  state <= S_HALT;
               else if (short_instr)
                  state <= S_FETCH;
               else
                  state <= S_EXEC;
            end
            S_EXEC:   state <= S_FETCH;
            S_HALT:   state <= S_HALT;
            default:  state <= S_INIT;
         endcase
      end
   end

   always_comb begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = 2'b00;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
      unique case (state)
         S_FETCH:  ir_enable = 1'b1;
         S_DECODE: pc_enable = 1'b1;
         S_EXEC: begin
            case (decoded_instruction)
               I_LOAD: begin
                  addr_sel         = 1'b1;
                  c_sel            = 1'b1;
                  write_reg_enable = 1'b1;
               end
               I_STORE: begin
                  addr_sel         = 1'b1;
                  ram_write_enable = 1'b1;
               end
               // source sits on both ALU inputs, OR passes it through
               I_MOVE: begin
                  operation        = 2'b11;
                  write_reg_enable = 1'b1;
               end
               I_ADD, I_SUB, I_AND, I_OR: begin
                  operation        = decoded_instruction[1:0];
                  write_reg_enable = 1'b1;
                  flags_reg_enable = 1'b1;
               end
               default: begin
                  pc_enable = take;
                  branch    = take;
               end
            endcase
         end
         S_HALT:   halt = 1'b1;
         default:  ;
      endcase
   end

endmodule
